// File: rtl/stats_pkg.sv
// stats_pkg: shared constants, stat indices, FSM state and round-robin pick for the stat scheduler
package stats_pkg;
  localparam int NUM_STATS = 6;
  typedef enum logic [2:0] {HUNGER, HAPPINESS, HEALTH, HYGIENE, ENERGY, SOCIAL} stat_t;
  typedef enum logic {IDLE, REQ} state_t;
  function automatic logic [2:0] rr_pick(logic [NUM_STATS-1:0] pend, logic [2:0] ptr);
    logic [2:0] j;
    rr_pick = ptr;
    for (int k = NUM_STATS - 1; k >= 0; k--) begin
      j = 3'((int'(ptr) + k) % NUM_STATS);
      if (pend[j]) rr_pick = j;
    end
  endfunction
endpackage

// File: rtl/stats_scheduler_if.sv
// stats_scheduler_if: valid/ready update command bus toward the stat register file
interface stats_scheduler_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_idx;
  logic       upd_inc;
  modport master(output upd_valid, upd_idx, upd_inc, input upd_ready);
  modport slave(input upd_valid, upd_idx, upd_inc, output upd_ready);
endinterface

// File: rtl/stat_cooldown.sv
// stat_cooldown: per-stat care cooldown, busy while the counter is nonzero
module stat_cooldown #(
  parameter int COOLDOWN = 2_700_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic busy
);
  localparam int W = $clog2(COOLDOWN + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= W'(COOLDOWN);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign busy = cnt != '0;
endmodule

// File: rtl/stats_scheduler.sv
// stats_scheduler: arbitrates decay ticks and care requests into one stat update command at a time
module stats_scheduler
  import stats_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int COOLDOWN = 2_700_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_STATS-1:0] care_req,
  input  logic [2:0]           random,
  stats_scheduler_if.master    upd,
  output logic                 tick_pulse,
  output logic [NUM_STATS-1:0] busy_mask,
  output logic [7:0]           miss_cnt
);
  localparam int PW = $clog2(TICK_DIV);
  state_t               state;
  logic [PW-1:0]        presc;
  logic [NUM_STATS-1:0] prev_care, care_pend, care_edge, grant_mask;
  logic                 decay_pend, decay_ev, grant_decay, grant_care;
  logic [2:0]           decay_idx, rr_ptr, rr_idx;
  assign decay_ev    = tick_pulse && random < 3'(NUM_STATS);
  assign rr_idx      = rr_pick(care_pend, rr_ptr);
  assign grant_decay = state == IDLE && decay_pend;
  assign grant_care  = state == IDLE && !decay_pend && |care_pend;
  assign grant_mask  = grant_care ? NUM_STATS'(1) << rr_idx : '0;
  // a stat being granted this cycle is already busy, so its own new edge is dropped
  assign care_edge   = care_req & ~prev_care & ~busy_mask & ~grant_mask;
  always_ff @(posedge clk)
    if (!reset_n) begin
      presc      <= '0;
      tick_pulse <= 1'b0;
      prev_care  <= '1;
      care_pend  <= '0;
      decay_pend <= 1'b0;
      decay_idx  <= '0;
      miss_cnt   <= '0;
      rr_ptr     <= '0;
    end else begin
      presc      <= presc == PW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
      tick_pulse <= presc == PW'(TICK_DIV - 1);
      prev_care  <= care_req;
      care_pend  <= (care_pend & ~grant_mask) | care_edge;
      decay_pend <= decay_ev || (decay_pend && !grant_decay);
      if (decay_ev) decay_idx <= random;
      if (decay_ev && decay_pend && !grant_decay && miss_cnt != 8'hff) miss_cnt <= miss_cnt + 1'b1;
      if (grant_care) rr_ptr <= rr_idx == 3'(SOCIAL) ? 3'(HUNGER) : rr_idx + 3'd1;
    end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state         <= IDLE;
      upd.upd_valid <= 1'b0;
      upd.upd_idx   <= '0;
      upd.upd_inc   <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_decay || grant_care) begin
        state         <= REQ;
        upd.upd_valid <= 1'b1;
        upd.upd_idx   <= grant_decay ? decay_idx : rr_idx;
        upd.upd_inc   <= grant_decay;
      end
    end else if (upd.upd_ready) begin
      state         <= IDLE;
      upd.upd_valid <= 1'b0;
    end
  for (genvar i = 0; i < NUM_STATS; i++) begin : g_cd
    stat_cooldown #(.COOLDOWN(COOLDOWN)) u_cd (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (grant_mask[i]),
      .busy   (busy_mask[i])
    );
  end
endmodule

// File: tb/tb_stats_scheduler.sv
// tb_stats_scheduler: directed scenarios plus randomized traffic against a cycle-numbered reference model
module tb_stats_scheduler;
  import stats_pkg::*;
  localparam int TD = 8, CD = 4;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [5:0] care_req = '0;
  logic [2:0] random = 3'd2;
  logic       tick_pulse;
  logic [5:0] busy_mask;
  logic [7:0] miss_cnt;
  stats_scheduler_if bus();
  stats_scheduler #(.TICK_DIV(TD), .COOLDOWN(CD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .care_req  (care_req),
    .random    (random),
    .upd       (bus.master),
    .tick_pulse(tick_pulse),
    .busy_mask (busy_mask),
    .miss_cnt  (miss_cnt)
  );
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  // model: cycle number since reset release, decay slot (-1 = empty), busy expressed as an end cycle
  int cyc = -1, dpend = -1, rr = 0, miss = 0, m_idx = 0;
  int busy_until[6] = '{-1, -1, -1, -1, -1, -1};
  bit m_valid = 1'b0, m_inc = 1'b0;
  bit [5:0] cpend = '0, prev = '1;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    int g = -1;
    bit tick_prev = cyc >= 0 && cyc % TD == TD - 1;
    if (!reset_n) begin
      cyc = -1; dpend = -1; rr = 0; miss = 0; cpend = '0; prev = '1;
      m_valid = 0; m_idx = 0; m_inc = 0;
      foreach (busy_until[i]) busy_until[i] = -1;
      return;
    end
    if (!m_valid) begin
      if (dpend >= 0) begin
        g = dpend; dpend = -1; m_inc = 1;
      end else begin
        for (int o = 0; o < 6; o++) if (g < 0 && cpend[(rr + o) % 6]) g = (rr + o) % 6;
        if (g >= 0) begin
          m_inc = 0; cpend[g] = 0; busy_until[g] = cyc + 1 + CD; rr = (g + 1) % 6;
        end
      end
      if (g >= 0) begin m_valid = 1; m_idx = g; end
    end else if (bus.upd_ready) m_valid = 0;
    if (tick_prev && int'(random) < 6) begin
      if (dpend >= 0) miss = miss == 255 ? 255 : miss + 1;
      dpend = int'(random);
    end
    for (int i = 0; i < 6; i++)
      if (care_req[i] && !prev[i] && cyc >= busy_until[i]) cpend[i] = 1;
    prev = care_req;
    cyc++;
  endtask

  always @(posedge clk) begin
    bit [5:0] eb;
    model_edge();
    #1;
    for (int i = 0; i < 6; i++) eb[i] = cyc < busy_until[i];
    chk("upd_valid", int'(bus.upd_valid), int'(m_valid));
    if (m_valid) begin
      chk("upd_idx", int'(bus.upd_idx), m_idx);
      chk("upd_inc", int'(bus.upd_inc), int'(m_inc));
    end
    chk("tick_pulse", int'(tick_pulse), int'(cyc >= 0 && cyc % TD == TD - 1));
    chk("busy_mask", int'(busy_mask), int'(eb));
    chk("miss_cnt", int'(miss_cnt), miss);
  end

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pin_zero(string name);
    chk({name, "_valid"}, int'(bus.upd_valid), 0);
    chk({name, "_idx"}, int'(bus.upd_idx), 0);
    chk({name, "_inc"}, int'(bus.upd_inc), 0);
    chk({name, "_tick"}, int'(tick_pulse), 0);
    chk({name, "_busy"}, int'(busy_mask), 0);
    chk({name, "_miss"}, int'(miss_cnt), 0);
  endtask

  task automatic pin_cmd(string name, int idx, int inc);
    chk({name, "_valid"}, int'(bus.upd_valid), 1);
    chk({name, "_idx"}, int'(bus.upd_idx), idx);
    chk({name, "_inc"}, int'(bus.upd_inc), inc);
  endtask

  initial begin
    bus.upd_ready = 1'b1;
    @(negedge clk); pin_zero("rst");
    @(negedge clk); reset_n = 1'b1;
    wait_cyc(7);  chk("t1_tick7", int'(tick_pulse), 1);
    wait_cyc(8);  chk("t1_gap8", int'(bus.upd_valid), 0);
    wait_cyc(9);  pin_cmd("t1_c9", 2, 1);
    wait_cyc(10); chk("t1_gap10", int'(bus.upd_valid), 0);
    wait_cyc(17); pin_cmd("t1_c17", 2, 1);
    wait_cyc(18); random = 3'd6;
    wait_cyc(25); chk("t5_r6", int'(bus.upd_valid), 0);
    wait_cyc(26); random = 3'd7;
    wait_cyc(33); chk("t5_r7", int'(bus.upd_valid), 0); chk("t5_miss", int'(miss_cnt), 0);
    wait_cyc(34); care_req = 6'b001001;
    wait_cyc(36); pin_cmd("t2_first", 0, 0);
    wait_cyc(37); chk("t2_gap", int'(bus.upd_valid), 0);
    wait_cyc(38); pin_cmd("t2_second", 3, 0); chk("t2_busy", int'(busy_mask), 6'b001001);
    wait_cyc(40); care_req = '0;
    wait_cyc(42); care_req = 6'b000010;
    wait_cyc(44); pin_cmd("t4_first", 1, 0);
    wait_cyc(45); care_req = '0;
    wait_cyc(46); care_req = 6'b000010; chk("t4_busy", int'(busy_mask[1]), 1);
    wait_cyc(48); chk("t4_dropped", int'(bus.upd_valid), 0); chk("t4_free", int'(busy_mask), 0);
    care_req = '0;
    wait_cyc(50); care_req = 6'b000010;
    wait_cyc(52); pin_cmd("t4_second", 1, 0);
    wait_cyc(53); care_req = '0; random = 3'd4; bus.upd_ready = 1'b0;
    wait_cyc(60); pin_cmd("t3_hold60", 4, 1);
    wait_cyc(72); random = 3'd7;
    wait_cyc(75); pin_cmd("t3_hold75", 4, 1); chk("t3_miss", int'(miss_cnt), 1);
    wait_cyc(76); bus.upd_ready = 1'b1;
    wait_cyc(77); chk("t3_idle", int'(bus.upd_valid), 0);
    wait_cyc(78); pin_cmd("t3_second", 4, 1);
    wait_cyc(80); chk("t3_done", int'(bus.upd_valid), 0);
    bus.upd_ready = 1'b0; random = 3'd0;
    wait_cyc(2200); chk("sat_miss", int'(miss_cnt), 255); care_req = 6'b100000;
    wait_cyc(2202); reset_n = 1'b0;
    @(negedge clk); pin_zero("t6");
    reset_n = 1'b1; random = 3'd7; bus.upd_ready = 1'b1;
    repeat (24) begin
      @(negedge clk);
      chk("t6_quiet", int'(bus.upd_valid), 0);
    end
    care_req = '0;
    repeat (1500) begin
      @(negedge clk);
      reset_n = $urandom_range(0, 299) != 0;
      random = 3'($urandom_range(0, 7));
      bus.upd_ready = $urandom_range(0, 3) != 0;
      care_req ^= 6'($urandom) & 6'($urandom) & 6'($urandom);
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
